// File: rtl/usb_bus_direction_ctrl_pkg.sv
// Shared USB PHY types: bus-direction FSM states, J-state line levels and a
// small helper used to size the direction controller's interval counter.
package usb_phy_pkg;

  typedef enum logic [2:0] {
    RX     = 3'd0,
    PRE_TX = 3'd1,
    TX     = 3'd2,
    POST_J = 3'd3,
    TA_RX  = 3'd4
  } bus_dir_state_t;

  localparam logic J_DP = 1'b1;
  localparam logic J_DM = 1'b0;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/usb_bus_direction_ctrl_if.sv
// Transmitter/receiver handshake and pad-side signals of the D+/D- direction
// controller; the controller takes the slave view.
interface usb_bus_direction_ctrl_if;

  logic tx_req;
  logic rx_busy;
  logic d_plus_out;
  logic d_minus_out;
  logic d_plus_pad;
  logic d_minus_pad;
  logic tx_grant;
  logic bus_oe;
  logic d_plus_drv;
  logic d_minus_drv;
  logic d_plus_in;
  logic d_minus_in;
  logic rx_enable;

  modport master (
    output tx_req, rx_busy, d_plus_out, d_minus_out, d_plus_pad, d_minus_pad,
    input  tx_grant, bus_oe, d_plus_drv, d_minus_drv, d_plus_in, d_minus_in, rx_enable
  );

  modport slave (
    input  tx_req, rx_busy, d_plus_out, d_minus_out, d_plus_pad, d_minus_pad,
    output tx_grant, bus_oe, d_plus_drv, d_minus_drv, d_plus_in, d_minus_in, rx_enable
  );

endinterface

// File: rtl/usb_sync_chain.sv
// Multi-flop synchroniser for one asynchronous pad line; every flop resets to
// the supplied idle level so the receiver sees a settled value out of reset.
module usb_sync_chain #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic rst_val,
  input  logic d,
  output logic q
);

  logic [SYNC_STAGES-1:0] sync_r;

  // Shift the raw pad value through the chain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_r <= {SYNC_STAGES{rst_val}};
    end else begin
      sync_r <= {sync_r[SYNC_STAGES-2:0], d};
    end
  end

  assign q = sync_r[SYNC_STAGES-1];

endmodule

// File: rtl/usb_bus_direction_ctrl.sv
// Sequenced D+/D- direction controller: grants the bus to the transmitter after
// a J turnaround, drives J after EOP, releases the pads and gates receive data.
module usb_bus_direction_ctrl
  import usb_phy_pkg::*;
#(
  parameter int SYNC_STAGES       = 2,
  parameter int TURNAROUND_CYCLES = 2,
  parameter int IDLE_DRIVE_CYCLES = 1
) (
  input logic                     clk,
  input logic                     rst,
  usb_bus_direction_ctrl_if.slave bus
);

  localparam int CNT_W = $clog2(max_int(TURNAROUND_CYCLES, IDLE_DRIVE_CYCLES) + 1);
  localparam logic [CNT_W-1:0] TA_LAST   = CNT_W'(TURNAROUND_CYCLES - 1);
  localparam logic [CNT_W-1:0] IDLE_LAST =
    CNT_W'((IDLE_DRIVE_CYCLES > 0) ? (IDLE_DRIVE_CYCLES - 1) : 0);
  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
  // With no post-EOP drive interval the bus goes straight into turnaround.
  localparam bus_dir_state_t TX_EXIT = (IDLE_DRIVE_CYCLES > 0) ? POST_J : TA_RX;

  bus_dir_state_t   state_r;
  bus_dir_state_t   state_next_s;
  logic [CNT_W-1:0] cnt_r;
  logic             sync_dp_s;
  logic             sync_dm_s;
  logic             tx_grant_s;
  logic             bus_oe_s;
  logic             dp_drv_s;
  logic             dm_drv_s;
  logic             dp_in_s;
  logic             dm_in_s;
  logic             rx_enable_s;

  usb_sync_chain #(.SYNC_STAGES(SYNC_STAGES)) u_sync_dp (
    .clk     (clk),
    .rst     (rst),
    .rst_val (J_DP),
    .d       (bus.d_plus_pad),
    .q       (sync_dp_s)
  );

  usb_sync_chain #(.SYNC_STAGES(SYNC_STAGES)) u_sync_dm (
    .clk     (clk),
    .rst     (rst),
    .rst_val (J_DM),
    .d       (bus.d_minus_pad),
    .q       (sync_dm_s)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= RX;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Interval counter: cleared on every state entry, saturates rather than wraps.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (state_next_s != state_r) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (cnt_r != CNT_MAX) begin
      cnt_r <= cnt_r + CNT_W'(1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

  // Next-state and output decode.
  always_comb begin
    state_next_s = state_r;
    tx_grant_s   = 1'b0;
    bus_oe_s     = 1'b0;
    dp_drv_s     = J_DP;
    dm_drv_s     = J_DM;
    dp_in_s      = J_DP;
    dm_in_s      = J_DM;
    rx_enable_s  = 1'b0;
    case (state_r)
      RX: begin
        rx_enable_s = 1'b1;
        dp_in_s     = sync_dp_s;
        dm_in_s     = sync_dm_s;
        if (bus.tx_req && !bus.rx_busy) begin
          state_next_s = PRE_TX;
        end else begin
          state_next_s = RX;
        end
      end
      PRE_TX: begin
        bus_oe_s = 1'b1;
        // A request withdrawn before the grant never saw the bus: skip POST_J.
        if (!bus.tx_req) begin
          state_next_s = TA_RX;
        end else if (cnt_r == TA_LAST) begin
          state_next_s = TX;
        end else begin
          state_next_s = PRE_TX;
        end
      end
      TX: begin
        bus_oe_s   = 1'b1;
        tx_grant_s = 1'b1;
        dp_drv_s   = bus.d_plus_out;
        dm_drv_s   = bus.d_minus_out;
        if (!bus.tx_req) begin
          state_next_s = TX_EXIT;
        end else begin
          state_next_s = TX;
        end
      end
      POST_J: begin
        bus_oe_s = 1'b1;
        if (cnt_r == IDLE_LAST) begin
          state_next_s = TA_RX;
        end else begin
          state_next_s = POST_J;
        end
      end
      TA_RX: begin
        if (cnt_r == TA_LAST) begin
          state_next_s = RX;
        end else begin
          state_next_s = TA_RX;
        end
      end
      default: begin
        state_next_s = RX;
      end
    endcase
  end

  assign bus.tx_grant    = tx_grant_s;
  assign bus.bus_oe      = bus_oe_s;
  assign bus.d_plus_drv  = dp_drv_s;
  assign bus.d_minus_drv = dm_drv_s;
  assign bus.d_plus_in   = dp_in_s;
  assign bus.d_minus_in  = dm_in_s;
  assign bus.rx_enable   = rx_enable_s;

endmodule

// File: tb/tb_usb_bus_direction_ctrl.sv
// Directed scoreboard bench for usb_bus_direction_ctrl: default parameters on
// dut0, IDLE_DRIVE_CYCLES = 0 on dut1, both fed the same stimulus.
module tb_usb_bus_direction_ctrl;
  import usb_phy_pkg::*;

  // Expected vector order: {tx_grant, bus_oe, rx_enable, d_plus_drv, d_minus_drv, d_plus_in, d_minus_in}
  localparam logic [6:0] E_RX = 7'b0011010;
  localparam logic [6:0] E_JD = 7'b0101010;
  localparam logic [6:0] E_TA = 7'b0001010;

  typedef struct {
    string      tag;
    bit         sel;
    logic [6:0] vec;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req = 1'b0;
  logic       busy = 1'b0;
  logic [1:0] txd = 2'b10;
  logic [1:0] pad = 2'b10;
  exp_t       sb[$];
  int         errors = 0;
  int         checks = 0;

  usb_bus_direction_ctrl_if bif0 ();
  usb_bus_direction_ctrl_if bif1 ();

  assign bif0.tx_req      = req;
  assign bif0.rx_busy     = busy;
  assign bif0.d_plus_out  = txd[1];
  assign bif0.d_minus_out = txd[0];
  assign bif0.d_plus_pad  = pad[1];
  assign bif0.d_minus_pad = pad[0];
  assign bif1.tx_req      = req;
  assign bif1.rx_busy     = busy;
  assign bif1.d_plus_out  = txd[1];
  assign bif1.d_minus_out = txd[0];
  assign bif1.d_plus_pad  = pad[1];
  assign bif1.d_minus_pad = pad[0];

  usb_bus_direction_ctrl #(
    .SYNC_STAGES(2), .TURNAROUND_CYCLES(2), .IDLE_DRIVE_CYCLES(1)
  ) dut0 (.clk(clk), .rst(rst), .bus(bif0.slave));

  usb_bus_direction_ctrl #(
    .SYNC_STAGES(2), .TURNAROUND_CYCLES(2), .IDLE_DRIVE_CYCLES(0)
  ) dut1 (.clk(clk), .rst(rst), .bus(bif1.slave));

  always #5 clk = ~clk;

  function automatic logic [6:0] ftx(input logic [1:0] d);
    return {3'b110, d, 2'b10};
  endfunction

  function automatic logic [6:0] frx(input logic [1:0] p);
    return {5'b00110, p};
  endfunction

  function automatic logic [6:0] observe(input bit sel);
    if (sel)
      return {bif1.tx_grant, bif1.bus_oe, bif1.rx_enable, bif1.d_plus_drv,
              bif1.d_minus_drv, bif1.d_plus_in, bif1.d_minus_in};
    else
      return {bif0.tx_grant, bif0.bus_oe, bif0.rx_enable, bif0.d_plus_drv,
              bif0.d_minus_drv, bif0.d_plus_in, bif0.d_minus_in};
  endfunction

  task automatic push_exp(input string tag, input bit sel, input logic [6:0] v);
    exp_t e;
    e.tag = tag;
    e.sel = sel;
    e.vec = v;
    sb.push_back(e);
  endtask

  task automatic check_head();
    exp_t       e;
    logic [6:0] o;
    e = sb.pop_front();
    o = observe(e.sel);
    checks++;
    assert (o === e.vec)
    else begin
      errors++;
      $error("FAIL %s dut%0d observed=%b expected=%b", e.tag, e.sel, o, e.vec);
    end
  endtask

  task automatic step(input string tag, input bit sel, input logic r, input logic b,
                      input logic [1:0] t, input logic [1:0] p, input logic [6:0] v);
    req  = r;
    busy = b;
    txd  = t;
    pad  = p;
    push_exp(tag, sel, v);
    @(posedge clk);
    #1;
    check_head();
  endtask

  initial begin
    // Reset held with pads toggling
    step("rst_hold0", 0, 1'b0, 1'b0, 2'b10, 2'b01, E_RX);
    step("rst_hold1", 0, 1'b0, 1'b0, 2'b10, 2'b10, E_RX);
    step("rst_hold2", 1, 1'b0, 1'b0, 2'b10, 2'b01, E_RX);
    rst = 1'b0;
    step("idle", 0, 1'b0, 1'b0, 2'b10, 2'b10, E_RX);

    // Basic grant / transmit / release sequence
    step("pre0", 0, 1'b1, 1'b0, 2'b10, 2'b10, E_JD);
    step("pre1", 0, 1'b1, 1'b0, 2'b10, 2'b10, E_JD);
    step("tx01", 0, 1'b1, 1'b0, 2'b01, 2'b10, ftx(2'b01));
    step("tx10", 0, 1'b1, 1'b0, 2'b10, 2'b10, ftx(2'b10));
    step("tx00", 0, 1'b1, 1'b0, 2'b00, 2'b10, ftx(2'b00));
    step("tx01b", 0, 1'b1, 1'b0, 2'b01, 2'b10, ftx(2'b01));
    step("tx10b", 0, 1'b1, 1'b0, 2'b10, 2'b10, ftx(2'b10));
    step("tx00b", 0, 1'b1, 1'b0, 2'b00, 2'b10, ftx(2'b00));
    step("post_j", 0, 1'b0, 1'b0, 2'b00, 2'b10, E_JD);
    step("ta0", 0, 1'b0, 1'b0, 2'b00, 2'b10, E_TA);
    step("ta1", 0, 1'b0, 1'b0, 2'b00, 2'b10, E_TA);
    step("rx_back", 0, 1'b0, 1'b0, 2'b00, 2'b10, E_RX);

    // Request held off by a busy receiver, then simultaneous release
    for (int i = 0; i < 5; i++) step("busy_hold", 0, 1'b1, 1'b1, 2'b10, 2'b10, E_RX);
    step("busy_fall", 0, 1'b1, 1'b0, 2'b10, 2'b10, E_JD);
    step("busy_pre1", 0, 1'b1, 1'b0, 2'b10, 2'b10, E_JD);
    step("busy_tx", 0, 1'b1, 1'b0, 2'b01, 2'b10, ftx(2'b01));
    step("busy_post", 0, 1'b0, 1'b0, 2'b01, 2'b10, E_JD);
    step("busy_ta0", 0, 1'b0, 1'b0, 2'b01, 2'b10, E_TA);
    step("busy_ta1", 0, 1'b0, 1'b0, 2'b01, 2'b10, E_TA);
    step("busy_rx", 0, 1'b0, 1'b0, 2'b01, 2'b10, E_RX);

    // Request withdrawn during PRE_TX
    step("abort_pre", 0, 1'b1, 1'b0, 2'b10, 2'b10, E_JD);
    step("abort_ta0", 0, 1'b0, 1'b0, 2'b10, 2'b10, E_TA);
    step("abort_ta1", 0, 1'b1, 1'b0, 2'b10, 2'b10, E_TA);
    step("abort_rx", 0, 1'b0, 1'b0, 2'b10, 2'b10, E_RX);

    // Synchroniser latency and receive masking
    step("sync_s1", 0, 1'b0, 1'b0, 2'b10, 2'b01, frx(2'b10));
    step("sync_s2", 0, 1'b0, 1'b0, 2'b10, 2'b01, frx(2'b01));
    step("sync_s3", 0, 1'b0, 1'b0, 2'b10, 2'b01, frx(2'b01));
    step("mask_pre0", 0, 1'b1, 1'b0, 2'b10, 2'b01, E_JD);
    step("mask_pre1", 0, 1'b1, 1'b0, 2'b10, 2'b01, E_JD);
    step("mask_tx", 0, 1'b1, 1'b0, 2'b01, 2'b01, ftx(2'b01));
    step("mask_post", 0, 1'b0, 1'b0, 2'b01, 2'b01, E_JD);
    step("mask_ta0", 0, 1'b0, 1'b0, 2'b01, 2'b01, E_TA);
    step("mask_ta1", 0, 1'b0, 1'b0, 2'b01, 2'b01, E_TA);
    step("stale_rx", 0, 1'b0, 1'b0, 2'b01, 2'b01, frx(2'b01));
    step("pad_j1", 0, 1'b0, 1'b0, 2'b10, 2'b10, frx(2'b01));
    step("pad_j2", 0, 1'b0, 1'b0, 2'b10, 2'b10, E_RX);

    // Async reset in the middle of TX
    step("rtx_pre0", 0, 1'b1, 1'b0, 2'b10, 2'b10, E_JD);
    step("rtx_pre1", 0, 1'b1, 1'b0, 2'b10, 2'b10, E_JD);
    step("rtx_tx", 0, 1'b1, 1'b0, 2'b01, 2'b10, ftx(2'b01));
    #2;
    rst = 1'b1;
    #1;
    push_exp("async_rst", 0, E_RX);
    check_head();
    push_exp("async_rst_d1", 1, E_RX);
    check_head();
    #1;
    req = 1'b0;
    rst = 1'b0;
    step("post_rst_idle", 0, 1'b0, 1'b0, 2'b10, 2'b10, E_RX);
    step("rep_pre0", 0, 1'b1, 1'b0, 2'b10, 2'b10, E_JD);
    step("rep_pre1", 0, 1'b1, 1'b0, 2'b10, 2'b10, E_JD);
    step("rep_tx00", 0, 1'b1, 1'b0, 2'b00, 2'b10, ftx(2'b00));
    step("rep_tx01", 0, 1'b1, 1'b0, 2'b01, 2'b10, ftx(2'b01));
    step("rep_post", 0, 1'b0, 1'b0, 2'b01, 2'b10, E_JD);
    step("rep_ta0", 0, 1'b0, 1'b0, 2'b01, 2'b10, E_TA);
    step("rep_ta1", 0, 1'b0, 1'b0, 2'b01, 2'b10, E_TA);
    step("rep_rx", 0, 1'b0, 1'b0, 2'b01, 2'b10, E_RX);

    // IDLE_DRIVE_CYCLES = 0: TX goes straight to turnaround
    step("nd_pre0", 1, 1'b1, 1'b0, 2'b10, 2'b10, E_JD);
    step("nd_pre1", 1, 1'b1, 1'b0, 2'b10, 2'b10, E_JD);
    step("nd_tx", 1, 1'b1, 1'b0, 2'b01, 2'b10, ftx(2'b01));
    step("nd_ta0", 1, 1'b0, 1'b0, 2'b01, 2'b10, E_TA);
    step("nd_ta1", 1, 1'b0, 1'b0, 2'b01, 2'b10, E_TA);
    step("nd_rx", 1, 1'b0, 1'b0, 2'b01, 2'b10, E_RX);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
